// File: rtl/regfile_pkg.sv
// Shared parameters for the register-file writeback scoreboard.
//   BIT_WIDTH : register data width
//   REG_WIDTH : register index width
//   REG_SIZE  : number of registers (one busy bit each)
//   SRC_A/B   : round-robin pointer encoding (A = ALU, B = MEM)
package regfile_pkg;
  localparam int   BIT_WIDTH = 32;
  localparam int   REG_WIDTH = 4;
  localparam int   REG_SIZE  = 1 << REG_WIDTH;
  localparam logic SRC_A     = 1'b0;
  localparam logic SRC_B     = 1'b1;
endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the register-file write port.
// Ports:
//   i_clk      : clock
//   i_reset    : synchronous active-high reset (pointer back to A)
//   i_enable   : grants allowed and pointer may move (LOCK && !RESET)
//   i_a_valid  : source A requests
//   i_b_valid  : source B requests
//   o_a_grant  : A wins this cycle
//   o_b_grant  : B wins this cycle
module wb_rr_arbiter
  import regfile_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_a_valid,
  input  logic i_b_valid,
  output logic o_a_grant,
  output logic o_b_grant
);

  logic r_rr_ptr;
  logic w_contended;

  assign w_contended = i_a_valid & i_b_valid;

  // Grant selection: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    o_a_grant = 1'b0;
    o_b_grant = 1'b0;
    if (!i_enable) begin
      o_a_grant = 1'b0;
      o_b_grant = 1'b0;
    end else if (w_contended) begin
      if (r_rr_ptr == SRC_A) begin
        o_a_grant = 1'b1;
      end else begin
        o_b_grant = 1'b1;
      end
    end else begin
      o_a_grant = i_a_valid;
      o_b_grant = i_b_valid;
    end
  end

  // Pointer moves only after a contended grant, so a lone requester never steals priority.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr <= SRC_A;
    end else if (i_enable && w_contended) begin
      r_rr_ptr <= ~r_rr_ptr;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Register-file write-port owner and pending-write scoreboard.
// Arbitrates writebacks A (ALU) and B (MEM) onto RF_WE/RF_DR/RF_DIN, keeps one
// busy bit per register and stalls issue on RAW/WAW hazards.
// Ports:
//   CLK, RESET (sync, active high), LOCK (global enable)
//   ISSUE_VALID/USE1/SR1/USE2/SR2/WR/DR : issue-stage instruction
//   STALL                               : instruction not accepted this cycle
//   A_VALID/A_DR/A_DATA, A_READY        : ALU writeback request / grant
//   B_VALID/B_DR/B_DATA, B_READY        : MEM writeback request / grant
//   RF_WE/RF_DR/RF_DIN                  : register file write port
//   BUSY                                : busy vector
module regfile_wb_scoreboard
  import regfile_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 LOCK,
  input  logic                 ISSUE_VALID,
  input  logic                 ISSUE_USE1,
  input  logic [REG_WIDTH-1:0] ISSUE_SR1,
  input  logic                 ISSUE_USE2,
  input  logic [REG_WIDTH-1:0] ISSUE_SR2,
  input  logic                 ISSUE_WR,
  input  logic [REG_WIDTH-1:0] ISSUE_DR,
  output logic                 STALL,
  input  logic                 A_VALID,
  input  logic [REG_WIDTH-1:0] A_DR,
  input  logic [BIT_WIDTH-1:0] A_DATA,
  output logic                 A_READY,
  input  logic                 B_VALID,
  input  logic [REG_WIDTH-1:0] B_DR,
  input  logic [BIT_WIDTH-1:0] B_DATA,
  output logic                 B_READY,
  output logic                 RF_WE,
  output logic [REG_WIDTH-1:0] RF_DR,
  output logic [BIT_WIDTH-1:0] RF_DIN,
  output logic [REG_SIZE-1:0]  BUSY
);

  logic [REG_SIZE-1:0] r_busy;
  logic                w_enable;
  logic                w_a_grant;
  logic                w_b_grant;
  logic [REG_SIZE-1:0] w_wr_onehot;
  logic [REG_SIZE-1:0] w_set_onehot;
  logic [REG_SIZE-1:0] w_hit_vec;
  logic [REG_SIZE-1:0] w_busy_next;
  logic                w_hazard;
  logic                w_accept;

  assign w_enable = LOCK & ~RESET;

  wb_rr_arbiter u_arb (
    .i_clk     (CLK),
    .i_reset   (RESET),
    .i_enable  (w_enable),
    .i_a_valid (A_VALID),
    .i_b_valid (B_VALID),
    .o_a_grant (w_a_grant),
    .o_b_grant (w_b_grant)
  );

  assign A_READY = w_a_grant;
  assign B_READY = w_b_grant;
  assign RF_WE   = w_a_grant | w_b_grant;

  // Write-port mux from the granted source; zero when idle.
  always_comb begin
    RF_DR  = '0;
    RF_DIN = '0;
    if (w_a_grant) begin
      RF_DR  = A_DR;
      RF_DIN = A_DATA;
    end else if (w_b_grant) begin
      RF_DR  = B_DR;
      RF_DIN = B_DATA;
    end else begin
      RF_DR  = '0;
      RF_DIN = '0;
    end
  end

  // A register written this cycle is forwarded by the regfile, so it no longer blocks.
  assign w_wr_onehot = {{(REG_SIZE-1){1'b0}}, RF_WE} << RF_DR;
  assign w_hit_vec   = r_busy & ~w_wr_onehot;
  assign w_hazard    = (ISSUE_USE1 & w_hit_vec[ISSUE_SR1])
                     | (ISSUE_USE2 & w_hit_vec[ISSUE_SR2])
                     | (ISSUE_WR   & w_hit_vec[ISSUE_DR]);

  // Frozen or resetting: hold any presented instruction.
  always_comb begin
    STALL = 1'b0;
    if (!w_enable) begin
      STALL = ISSUE_VALID;
    end else begin
      STALL = ISSUE_VALID & w_hazard;
    end
  end

  assign w_accept     = ISSUE_VALID & ~STALL & w_enable;
  assign w_set_onehot = {{(REG_SIZE-1){1'b0}}, (w_accept & ISSUE_WR)} << ISSUE_DR;
  // Set is applied after clear so a new producer of the same register wins.
  assign w_busy_next  = (r_busy & ~w_wr_onehot) | w_set_onehot;

  // Busy vector: cleared on reset, frozen while LOCK is low.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_busy <= '0;
    end else if (LOCK) begin
      r_busy <= w_busy_next;
    end else begin
      r_busy <= r_busy;
    end
  end

  assign BUSY = r_busy;

endmodule
